// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: slice layout, idle values and FSM states.
package rtc_bus_pkg;

  // Bit offsets of the control lines inside the nibble that sits above the data byte.
  localparam int AD_BIT = 3;
  localparam int RD_BIT = 2;
  localparam int CS_BIT = 1;
  localparam int WR_BIT = 0;

  // Idle control nibble {AD,RD,CS,WR}; the idle data byte is all zero.
  localparam logic [3:0] IDLE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_GUARD
  } state_t;

  function automatic int slice_w(input int dw);
    return dw + 4;
  endfunction

endpackage

// File: rtl/rtc_prio_pick.sv
// Masked priority encoder: first requester at or after the pointer (RR) or from index 0.
module rtc_prio_pick #(
  parameter int N_CH = 6
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] pointer,
  input  logic                    rr,
  output logic [$clog2(N_CH)-1:0] winner,
  output logic                    valid
);

  localparam int IW = $clog2(N_CH);

  always_comb begin : scan
    int base;
    int c;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    base   = rr ? int'(pointer) : 0;
    for (int k = 0; k < N_CH; k++) begin
      c = base + k;
      if (c >= N_CH) c = c - N_CH;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        winner = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Request/grant owner arbiter for the shared RTC parallel bus with guard interval and timeout.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int N_CH  = 6,
  parameter int DW    = 8,
  parameter int GUARD = 1,
  parameter int RR    = 1,
  parameter int TMO   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CH-1:0]              req,
  input  logic [N_CH-1:0]              done,
  input  logic [N_CH*slice_w(DW)-1:0]  bus_in,
  output logic [N_CH-1:0]              grant,
  output logic [$clog2(N_CH)-1:0]      owner,
  output logic                         busy,
  output logic                         tmo_err,
  output logic                         AD,
  output logic                         RD,
  output logic                         CS,
  output logic                         WR,
  output logic [DW-1:0]                ADout
);

  localparam int SW = slice_w(DW);
  localparam int OW = $clog2(N_CH);
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST   = CW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [3:0]    GUARD_LAST = 4'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [SW-1:0] IDLE_BUS   = {IDLE_WORD, {DW{1'b0}}};

  state_t          state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;
  logic [SW-1:0]   bus_q, bus_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic [3:0]      gcnt_q, gcnt_d;

  logic [OW-1:0]   pick_idx;
  logic            pick_valid;
  logic [SW-1:0]   owner_slice;
  logic            user_rel;
  logic            tmo_hit;

  rtc_prio_pick #(.N_CH(N_CH)) u_pick (
    .req     (req),
    .pointer (ptr_q),
    .rr      (RR != 0),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  assign owner_slice = bus_in[int'(owner_q)*SW +: SW];
  assign user_rel    = done[owner_q] | ~req[owner_q];
  assign tmo_hit     = (TMO != 0) && (ocnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    bus_d   = IDLE_BUS;
    ocnt_d  = ocnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = N_CH'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          ocnt_d  = '0;
          ptr_d   = (pick_idx == OW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (user_rel || tmo_hit) begin
          grant_d = '0;
          busy_d  = 1'b0;
          // A timeout only counts as an error when the owner did not release on its own.
          tmo_d   = tmo_hit & ~user_rel;
          gcnt_d  = '0;
          state_d = (GUARD > 0) ? ST_GUARD : ST_IDLE;
        end else begin
          bus_d  = owner_slice;
          ocnt_d = ocnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == GUARD_LAST) state_d = ST_IDLE;
        else                      gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      bus_q   <= IDLE_BUS;
      ocnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      bus_q   <= bus_d;
      ocnt_q  <= ocnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign tmo_err = tmo_q;
  assign AD      = bus_q[DW+AD_BIT];
  assign RD      = bus_q[DW+RD_BIT];
  assign CS      = bus_q[DW+CS_BIT];
  assign WR      = bus_q[DW+WR_BIT];
  assign ADout   = bus_q[DW-1:0];

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: two configurations driven in parallel against a transaction-level model.
module tb_rtc_bus_arbiter;

  localparam int N  = 6;
  localparam int DW = 8;
  localparam int SW = DW + 4;
  localparam int NI = 2;
  localparam logic [SW-1:0] IDLE = 12'hF00;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req, done;
  logic [N*SW-1:0]  bus_in;
  logic [N-1:0]     grant [NI];
  logic [2:0]       owner [NI];
  logic             busy [NI], tmo_err [NI], ad [NI], rd [NI], cs [NI], wr [NI];
  logic [DW-1:0]    adout [NI];

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.N_CH(N), .DW(DW), .GUARD(2), .RR(1), .TMO(10)) dut_rr (
    .clk(clk), .reset(reset), .req(req), .done(done), .bus_in(bus_in),
    .grant(grant[0]), .owner(owner[0]), .busy(busy[0]), .tmo_err(tmo_err[0]),
    .AD(ad[0]), .RD(rd[0]), .CS(cs[0]), .WR(wr[0]), .ADout(adout[0]));

  rtc_bus_arbiter #(.N_CH(N), .DW(DW), .GUARD(0), .RR(0), .TMO(0)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .done(done), .bus_in(bus_in),
    .grant(grant[1]), .owner(owner[1]), .busy(busy[1]), .tmo_err(tmo_err[1]),
    .AD(ad[1]), .RD(rd[1]), .CS(cs[1]), .WR(wr[1]), .ADout(adout[1]));

  // Reference model: who owns the bus, for how long, and how many idle cycles remain.
  int            rr_p    [NI] = '{1, 0};
  int            guard_p [NI] = '{2, 0};
  int            tmo_p   [NI] = '{10, 0};
  bit            m_own   [NI];
  int            m_cur   [NI];
  int            m_age   [NI];
  int            m_wait  [NI];
  int            m_ptr   [NI];
  bit            m_tmo   [NI];
  logic [SW-1:0] m_bus   [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int ord0[$], ord1[$], gaps0[$], lens0[$];
  int gap0, len0, tmo_cnt0;
  bit prev0, prev1, kept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] slice_of(input int i);
    return bus_in[i*SW +: SW];
  endfunction

  task automatic model_reset(input int j);
    m_own[j] = 0; m_cur[j] = 0; m_age[j] = 0; m_wait[j] = 0; m_ptr[j] = 0;
    m_tmo[j] = 0; m_bus[j] = IDLE;
  endtask

  task automatic model_step(input int j);
    bit user, tout;
    int base, c;
    m_tmo[j] = 0;
    m_bus[j] = IDLE;
    if (m_own[j]) begin
      user = done[m_cur[j]] || !req[m_cur[j]];
      tout = (tmo_p[j] != 0) && (m_age[j] == tmo_p[j] - 1);
      if (user || tout) begin
        m_own[j]  = 0;
        m_tmo[j]  = tout && !user;
        m_wait[j] = guard_p[j];
      end else begin
        m_bus[j] = slice_of(m_cur[j]);
        m_age[j]++;
      end
    end else if (m_wait[j] > 0) begin
      m_wait[j]--;
    end else if (req != '0) begin
      base = (rr_p[j] != 0) ? m_ptr[j] : 0;
      for (int k = N - 1; k >= 0; k--) begin
        c = (base + k) % N;
        if (req[c]) m_cur[j] = c;
      end
      m_own[j] = 1;
      m_age[j] = 0;
      m_ptr[j] = (m_cur[j] + 1) % N;
    end
  endtask

  function automatic logic [22:0] expv(input int j);
    logic [N-1:0] g;
    g = m_own[j] ? (N'(1) << m_cur[j]) : '0;
    return {g, 3'(m_cur[j]), m_own[j], m_tmo[j], m_bus[j]};
  endfunction

  function automatic logic [22:0] obsv(input int j);
    return {grant[j], owner[j], busy[j], tmo_err[j], ad[j], rd[j], cs[j], wr[j], adout[j]};
  endfunction

  task automatic clear_obs();
    ord0.delete(); ord1.delete(); gaps0.delete(); lens0.delete();
    gap0 = 0; len0 = 0; tmo_cnt0 = 0; prev0 = 0; prev1 = 0;
  endtask

  task automatic observe();
    if (busy[0] && !prev0) begin ord0.push_back(int'(owner[0])); gaps0.push_back(gap0); end
    if (!busy[0] && prev0) lens0.push_back(len0);
    len0 = busy[0] ? (prev0 ? len0 + 1 : 1) : 0;
    gap0 = busy[0] ? 0 : gap0 + 1;
    if (tmo_err[0]) tmo_cnt0++;
    if (busy[1] && !prev1) ord1.push_back(int'(owner[1]));
    prev0 = busy[0];
    prev1 = busy[1];
  endtask

  // Inputs are set at the falling edge; model and DUT both sample them at the next rising edge.
  task automatic step();
    @(posedge clk);
    for (int j = 0; j < NI; j++) model_step(j);
    #1;
    check("inst0_rr", obsv(0), expv(0));
    check("inst1_fp", obsv(1), expv(1));
    observe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int j = 0; j < NI; j++) model_reset(j);
    check("reset_i0", obsv(0), {6'b0, 3'b0, 1'b0, 1'b0, IDLE});
    check("reset_i1", obsv(1), {6'b0, 3'b0, 1'b0, 1'b0, IDLE});
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = '0; done = '0; bus_in = '0;
    #2;
    do_reset();

    // Single request on controller 2.
    bus_in[2*SW +: SW] = 12'h5A5;
    req = 6'b000100;
    step();
    check("single_grant", grant[0], 6'b000100);
    step();
    check("single_bus", {ad[0], rd[0], cs[0], wr[0], adout[0]}, 12'h5A5);
    done = 6'b000100;
    step();
    done = '0;
    check("single_release", {grant[0], ad[0], rd[0], cs[0], wr[0], adout[0]}, {6'b0, IDLE});
    req = '0;
    repeat (4) step();

    // Round robin with everyone requesting, each owner finishing after 4 cycles.
    do_reset();
    req = 6'b111111;
    for (int t = 0; t < 200 && ord0.size() < 7; t++) begin
      done = (m_own[0] && m_age[0] == 3) ? (N'(1) << m_cur[0]) : '0;
      step();
    end
    done = '0;
    check("rr_count", ord0.size(), 7);
    for (int i = 0; i < ord0.size() && i < 7; i++) check("rr_order", ord0[i], i % N);
    for (int i = 1; i < gaps0.size() && i < 7; i++) check("rr_gap", gaps0[i], 3);

    // Fixed priority: owner 1 twice, then 3, then 5.
    do_reset();
    req = 6'b101010;
    kept = 0;
    for (int t = 0; t < 24; t++) begin
      done = '0;
      if (m_own[1] && m_age[1] == 1) begin
        done[m_cur[1]] = 1'b1;
        if (m_cur[1] != 1 || kept) req[m_cur[1]] = 1'b0;
        else kept = 1;
      end
      step();
    end
    done = '0;
    check("fp_count", ord1.size(), 4);
    if (ord1.size() == 4) begin
      check("fp_o0", ord1[0], 1); check("fp_o1", ord1[1], 1);
      check("fp_o2", ord1[2], 3); check("fp_o3", ord1[3], 5);
    end

    // Timeout: owner 4 never finishes.
    do_reset();
    req = 6'b010000;
    repeat (30) step();
    check("tmo_pulses", tmo_cnt0, 2);
    check("tmo_len", (lens0.size() > 0) ? lens0[0] : -1, 10);

    // done arriving in the timeout cycle is a normal release.
    do_reset();
    req = 6'b010000;
    for (int t = 0; t < 30; t++) begin
      done = (m_own[0] && m_age[0] == 9) ? 6'b010000 : '0;
      step();
    end
    done = '0;
    check("tmo_done_same", tmo_cnt0, 0);
    check("tmo_done_len", (lens0.size() > 0) ? lens0[0] : -1, 10);

    // Non-owner done is ignored; owner dropping req releases.
    do_reset();
    req = 6'b000001;
    step(); step();
    done = 6'b000010;
    step();
    done = '0;
    check("ignore_owner", owner[0], 3'd0);
    check("ignore_busy", busy[0], 1'b1);
    req = '0;
    step();
    check("req_drop", busy[0], 1'b0);
    repeat (4) step();

    // Asynchronous reset while controller 3 owns the bus.
    do_reset();
    bus_in[3*SW +: SW] = 12'h03C;
    req = 6'b001000;
    repeat (3) step();
    check("own3", owner[0], 3'd3);
    do_reset();
    req = 6'b000001;
    step();
    check("after_reset_grant", grant[0], 6'b000001);

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      for (int i = 0; i < N; i++) if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      done = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 31) == 0) done[i] = 1'b1;
      if (m_own[0] && $urandom_range(0, 15) == 0) done[m_cur[0]] = 1'b1;
      bus_in = (N*SW)'({$urandom(), $urandom(), $urandom()});
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
